// File: rtl/riscv_fetch_pkg.sv
// Shared definitions for the fetch stage: opcodes, immediate-format codes,
// the NOP word, FSM state encoding and the opcode -> ImmSel decoder.
package riscv_fetch_pkg;

  // Base opcodes that carry an immediate the extensor must format
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // Immediate format select presented to the extensor
  typedef logic [1:0] imm_sel_t;
  localparam imm_sel_t IMM_I = 2'b00;
  localparam imm_sel_t IMM_S = 2'b01;
  localparam imm_sel_t IMM_B = 2'b10;
  localparam imm_sel_t IMM_J = 2'b11;

  // addi x0, x0, 0 -- what an empty IF/ID register shows after reset
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  // Fetch FSM states
  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t StIdle = 2'd0;
  localparam fetch_state_t StReq  = 2'd1;
  localparam fetch_state_t StFull = 2'd2;
  localparam fetch_state_t StDrop = 2'd3;

  // U-type and all non-immediate opcodes fall back to I; the extensor takes
  // U immediates from its dedicated Imm_U path, so the code is don't-care there.
  function automatic imm_sel_t imm_sel_decode(input logic [6:0] opcode);
    imm_sel_t sel;
    case (opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: sel = IMM_I;
      OPC_STORE:                      sel = IMM_S;
      OPC_BRANCH:                     sel = IMM_B;
      OPC_JAL:                        sel = IMM_J;
      default:                        sel = IMM_I;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/fetch_queue2.sv
// Two-entry {pc, inst} FIFO forming the IF/ID register.
// Entry 0 is always the head, so head outputs come straight from flops and
// stay stable until a pop or flush. Flush wins over push and pop.
module fetch_queue2
  import riscv_fetch_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  logic [31:0] push_pc_i,
  input  logic [31:0] push_inst_i,
  input  logic        pop_i,
  input  logic        flush_i,
  output logic [1:0]  count_o,
  output logic        head_valid_o,
  output logic [31:0] head_pc_o,
  output logic [31:0] head_inst_o
);

  logic [1:0]  count_q, count_d;
  logic [31:0] ent0_pc_q, ent0_pc_d;
  logic [31:0] ent0_inst_q, ent0_inst_d;
  logic [31:0] ent1_pc_q, ent1_pc_d;
  logic [31:0] ent1_inst_q, ent1_inst_d;

  // Next-state: shift on pop, write to the first free slot on push
  always_comb begin
    count_d     = count_q;
    ent0_pc_d   = ent0_pc_q;
    ent0_inst_d = ent0_inst_q;
    ent1_pc_d   = ent1_pc_q;
    ent1_inst_d = ent1_inst_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (count_q == 2'd0) begin
            ent0_pc_d   = push_pc_i;
            ent0_inst_d = push_inst_i;
          end else begin
            ent1_pc_d   = push_pc_i;
            ent1_inst_d = push_inst_i;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          ent0_pc_d   = ent1_pc_q;
          ent0_inst_d = ent1_inst_q;
          count_d     = count_q - 2'd1;
        end
        2'b11: begin
          // Pop frees the head; new word lands behind whatever remains
          if (count_q == 2'd1) begin
            ent0_pc_d   = push_pc_i;
            ent0_inst_d = push_inst_i;
          end else begin
            ent0_pc_d   = ent1_pc_q;
            ent0_inst_d = ent1_inst_q;
            ent1_pc_d   = push_pc_i;
            ent1_inst_d = push_inst_i;
          end
        end
        default: ;
      endcase
    end
  end

  // Queue state, cleared asynchronously to an empty queue showing a NOP
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q     <= 2'd0;
      ent0_pc_q   <= 32'h0;
      ent0_inst_q <= NOP_WORD;
      ent1_pc_q   <= 32'h0;
      ent1_inst_q <= NOP_WORD;
    end else begin
      count_q     <= count_d;
      ent0_pc_q   <= ent0_pc_d;
      ent0_inst_q <= ent0_inst_d;
      ent1_pc_q   <= ent1_pc_d;
      ent1_inst_q <= ent1_inst_d;
    end
  end

  assign count_o      = count_q;
  assign head_valid_o = (count_q != 2'd0);
  assign head_pc_o    = ent0_pc_q;
  assign head_inst_o  = ent0_inst_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: PC register, one-outstanding instruction-memory request FSM,
// IF/ID queue and ImmSel decode of the queue head for the immediate extensor.
module instr_fetch_stage
  import riscv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic [24:0] id_imm_field,
  output logic [1:0]  id_ImmSel
);

  localparam logic [31:0] PcInc = 32'(PC_STEP);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [1:0]   count, count_post;
  logic         in_req, push, pop;

  // Redirect overrides everything: a same-cycle ack is dropped and no pop happens
  assign in_req = (state_q == StReq);
  assign push   = in_req && imem_ack && !redirect_valid;
  assign pop    = id_valid && id_ready && !redirect_valid;

  fetch_queue2 u_queue (
    .clk_i        (clk),
    .rst_i        (rst),
    .push_i       (push),
    .push_pc_i    (pc_q),
    .push_inst_i  (imem_rdata),
    .pop_i        (pop),
    .flush_i      (redirect_valid),
    .count_o      (count),
    .head_valid_o (id_valid),
    .head_pc_o    (id_pc),
    .head_inst_o  (id_inst)
  );

  // Occupancy after this cycle's push/pop, used to decide REQ vs FULL
  always_comb begin
    count_post = count;
    if (push && !pop) begin
      count_post = count + 2'd1;
    end else if (!push && pop) begin
      count_post = count - 2'd1;
    end
  end

  // FSM next-state
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      // An unanswered request must have its ack swallowed before refetching
      if ((state_q == StReq || state_q == StDrop) && !imem_ack) begin
        state_d = StDrop;
      end else begin
        state_d = StReq;
      end
    end else begin
      case (state_q)
        StIdle: state_d = StReq;
        StReq: begin
          if (imem_ack) begin
            state_d = (count_post >= 2'd2) ? StFull : StReq;
          end
        end
        StFull: begin
          if (pop) begin
            state_d = StReq;
          end
        end
        StDrop: begin
          if (imem_ack) begin
            state_d = StReq;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // PC next-state; the add wraps naturally at 2^32
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc & ~32'h3;
    end else if (push) begin
      pc_d = pc_q + PcInc;
    end
  end

  // PC and FSM registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign imem_req     = in_req;
  assign imem_addr    = pc_q;
  assign id_imm_field = id_inst[31:7];
  assign id_ImmSel    = imm_sel_decode(id_inst[6:0]);

endmodule
